reaction_round_ctrl: RTL
========================

Name: reaction_round_ctrl

Overview:
- Round sequencer for the reaction-time tester.
- Takes synchronized start and react buttons from `ui_in` and runs the round state machine: idle, armed, go, done, false start.
- Generates a pseudo-random arming delay and times the reaction in milliseconds as 4-digit BCD.
- Its outputs feed the 7-segment/anode display driver and the GO LED on `uo_out`.

Parameters:
- CLKS_PER_MS, 10000, clk cycles per 1 ms tick (10 MHz clock).
- MIN_DELAY_MS, 1000, fixed part of the arming delay, in ms (max 4095).
- RAND_BITS, 11, LFSR bits added to the delay: random part is 0..2^RAND_BITS-1 ms (1..11).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_btn  in  1  start button level, already synchronized/debounced
- react_btn  in  1  react button level, already synchronized/debounced
- go_led  out  1  high while in GO
- busy  out  1  high in ARMED or GO
- result_valid  out  1  high in DONE after a valid react press
- false_start  out  1  high in FALSE
- timeout  out  1  high in DONE after 9999 saturation
- bcd_time  out  16  reaction time, 4 BCD digits, [15:12] thousands
- state  out  3  IDLE=0, ARMED=1, GO=2, DONE=3, FALSE=4

Behaviour:
- One clock domain; all registers update on the clk rising edge.
- Reset is synchronous, active-high, clk-only. It is honoured mid-round with no exceptions, and on the cycle after it is asserted:
  - state=IDLE; all outputs 0; bcd_time=16'h0000.
  - Edge-detect registers=0; prescaler=0; delay counter=0.
  - LFSR=16'hACE1.
- Edge detect: press = btn & ~btn_q. This gives one pulse per rising edge. A held button never re-triggers.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle in every state. It never reaches all-zero.
- ms prescaler:
  - Counts 0..CLKS_PER_MS-1; ms_tick is a 1-cycle pulse at CLKS_PER_MS-1, then wraps to 0.
  - Cleared to 0 on every state transition, so the first tick comes CLKS_PER_MS cycles after state entry.
- IDLE:
  - start press -> ARMED.
  - react press is ignored.
  - If start and react are pressed in the same cycle, start wins.
- Entering ARMED, from any start press:
  - delay_target = MIN_DELAY_MS + LFSR[RAND_BITS-1:0], using the LFSR value in the press cycle. Width is 13 bits.
  - delay_cnt=0; bcd_time=0; all result flags cleared.
- ARMED:
  - busy=1; delay_cnt += 1 on each ms_tick.
  - react press -> FALSE. This takes priority over delay expiry in the same cycle.
  - When ms_tick and delay_cnt+1 == delay_target -> GO.
  - start press is ignored.
- GO:
  - go_led=1, busy=1.
  - On ms_tick, bcd_time increments as BCD: each digit wraps 9->0 with carry into the next.
  - react press -> DONE with result_valid=1. A press wins over a same-cycle ms_tick; that tick is not counted.
  - ms_tick while bcd_time==16'h9999 -> DONE with timeout=1; bcd_time holds 9999 and does not wrap.
  - start press is ignored.
- Tick-to-press latency: a react press in the cycle after the Nth tick in GO yields bcd_time=N. Timing resolution is 1 ms; truncation error is under 1 ms.
- DONE:
  - bcd_time holds.
  - react press is ignored.
  - start press -> ARMED, starting a new round.
- FALSE:
  - false_start=1; bcd_time=0.
  - react press is ignored.
  - start press -> ARMED.
- Outputs are registered and decoded from state plus the flag registers. There is no combinational input-to-output path.
- Undefined state encodings (5..7) -> IDLE on the next cycle.

Test Plan:
Bench parameters: CLKS_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2.
1. Reset then idle:
   - Apply reset for 2 cycles, then release.
   - Required: state=0, all outputs 0, bcd_time=0000.
   - Then pulse react alone: state stays 0.
2. Normal round:
   - Press start, wait for go_led=1, then press react after exactly 5 ms_ticks.
   - Required: state=3, result_valid=1, bcd_time=16'h0005.
   - Required: go_led rose 3..6 ms after the start press.
3. BCD carry:
   - In GO, let 99 ticks pass, then 1 more, then press react.
   - Required: bcd_time=16'h0100 with no invalid digit at any point.
4. False start:
   - Press react during ARMED.
   - Required: state=4, false_start=1, go_led never asserted.
   - Then press start: state=1, false_start=0.
5. Timeout and hold:
   - In GO, press nothing for 10000 ticks while holding react high from before GO.
   - Required: DONE with timeout=1 and bcd_time=16'h9999; the held react causes no press.
6. Reset mid-GO and simultaneous events:
   - Assert reset at bcd_time=0042. Required: next cycle state=0, bcd_time=0.
   - Press start and react in the same cycle in IDLE. Required: state=1.

Source files
------------

// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the reaction-time tester: arming delay from an LFSR,
// millisecond reaction timing in 4-digit BCD, false-start and timeout detection.
module reaction_round_ctrl #(
  parameter int CLKS_PER_MS  = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        go_led,
  output logic        busy,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
  output logic [15:0] bcd_time,
  output logic [2:0]  state
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FALSE = 3'd4
  } state_t;

  state_t       state_q, state_n;
  logic         start_q, react_q;
  logic         start_p, react_p;
  logic [15:0]  lfsr;
  logic         lfsr_fb;
  logic [PW-1:0] presc;
  logic         ms_tick;
  logic [12:0]  delay_cnt, delay_target;
  logic [15:0]  bcd_q, bcd_inc;
  logic         rv_q, to_q;
  logic         carry;
  logic         bcd_max;
  logic         enter_armed;

  assign start_p = start_btn & ~start_q;
  assign react_p = react_btn & ~react_q;
  assign ms_tick = (presc == PW'(CLKS_PER_MS - 1));
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign bcd_max = (bcd_q == 16'h9999);
  assign enter_armed = (state_n == S_ARMED) && (state_q != S_ARMED);

  // Ripple BCD increment: a digit rolls 9->0 and passes the carry upward.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[i*4 +: 4] == 4'd9) begin
          bcd_inc[i*4 +: 4] = 4'd0;
        end else begin
          bcd_inc[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start_p) state_n = S_ARMED;
      S_ARMED: begin
        if (react_p)
          state_n = S_FALSE;
        else if (ms_tick && (delay_cnt + 13'd1 == delay_target))
          state_n = S_GO;
      end
      S_GO: begin
        if (react_p || (ms_tick && bcd_max)) state_n = S_DONE;
      end
      S_DONE:  if (start_p) state_n = S_ARMED;
      S_FALSE: if (start_p) state_n = S_ARMED;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      react_q      <= 1'b0;
      lfsr         <= 16'hACE1;
      presc        <= '0;
      delay_cnt    <= '0;
      delay_target <= '0;
      bcd_q        <= '0;
      rv_q         <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q <= state_n;
      start_q <= start_btn;
      react_q <= react_btn;
      lfsr    <= {lfsr[14:0], lfsr_fb};
      // Prescaler restarts on every transition so the first tick is a full ms away.
      if (state_n != state_q || ms_tick) presc <= '0;
      else                               presc <= presc + PW'(1);

      if (enter_armed) begin
        delay_target <= 13'(MIN_DELAY_MS) + 13'(lfsr[RAND_BITS-1:0]);
        delay_cnt    <= '0;
        bcd_q        <= '0;
        rv_q         <= 1'b0;
        to_q         <= 1'b0;
      end else begin
        case (state_q)
          S_ARMED: if (ms_tick) delay_cnt <= delay_cnt + 13'd1;
          S_GO: begin
            // A press beats a same-cycle tick; that tick is dropped.
            if (react_p)      rv_q <= 1'b1;
            else if (ms_tick) begin
              if (bcd_max) to_q  <= 1'b1;
              else         bcd_q <= bcd_inc;
            end
          end
          S_FALSE: bcd_q <= '0;
          default: ;
        endcase
      end
    end
  end

  assign state        = state_q;
  assign go_led       = (state_q == S_GO);
  assign busy         = (state_q == S_ARMED) || (state_q == S_GO);
  assign result_valid = (state_q == S_DONE) && rv_q;
  assign timeout      = (state_q == S_DONE) && to_q;
  assign false_start  = (state_q == S_FALSE);
  assign bcd_time     = bcd_q;

endmodule
